// File: rtl/ctrl_unit_p_pkg.sv
// Shared encodings for the microcoded control unit: opcodes, FSM states,
// bus source codes, control-vector bit positions and ALU operations.
package ctrl_unit_p_pkg;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LDAC   = 4'd1,
    OP_LDIAC  = 4'd2,
    OP_STAC   = 4'd3,
    OP_MVACR  = 4'd4,
    OP_MVRAC  = 4'd5,
    OP_MVACAR = 4'd6,
    OP_ADD    = 4'd7,
    OP_SUB    = 4'd8,
    OP_MUL    = 4'd9,
    OP_LSHIFT = 4'd10,
    OP_INAC   = 4'd11,
    OP_JPNZ   = 4'd12,
    OP_JMPZ   = 4'd13,
    OP_CLAC   = 4'd14,
    OP_END    = 4'd15
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WAIT, S_EXEC, S_JUMP, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS   = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_MUL    = 3'd3,
    ALU_LSHIFT = 3'd4
  } alu_op_e;

  // bus source codes
  localparam logic [3:0] RS_NONE = 4'd0;
  localparam logic [3:0] RS_PC   = 4'd1;
  localparam logic [3:0] RS_IR   = 4'd4;
  localparam logic [3:0] RS_AC   = 4'd5;
  localparam logic [3:0] RS_GPR0 = 4'd7;
  localparam logic [3:0] RS_DM   = 4'd12;
  localparam logic [3:0] RS_IM   = 4'd13;

  // control-vector bit positions
  localparam int CB_PC   = 0;
  localparam int CB_AR   = 1;
  localparam int CB_IR   = 2;
  localparam int CB_AC   = 3;
  localparam int CB_R    = 4;
  localparam int CB_DM   = 5;
  localparam int CB_ALU  = 6;
  localparam int CB_GPR0 = 7;

  // bus source code for general register index n (R(n+1))
  function automatic logic [3:0] rs_gpr(input logic [3:0] n);
    return RS_GPR0 + n;
  endfunction

endpackage

// File: rtl/ctrl_mul_timer.sv
// Down-counter that stretches the multiply over MUL_LAT cycles and flags
// the final cycle so the result strobe lands exactly once.
module ctrl_mul_timer #(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic last
);
  localparam logic [3:0] INIT = 4'(MUL_LAT - 1);

  logic [3:0] cnt;

  // load on decode, count down while the multiply executes
  always_ff @(posedge clk) begin
    if (!rst_n)                 cnt <= 4'd0;
    else if (load)              cnt <= INIT;
    else if (en && cnt != 4'd0) cnt <= cnt - 4'd1;
  end

  assign last = (cnt == 4'd0);

endmodule

// File: rtl/ctrl_unit_p.sv
// Control unit FSM: fetch/decode/execute sequencing for the accumulator
// datapath. Outputs decode from state plus the latched opcode; only the
// memory-ack and start qualified strobes depend on inputs.
module ctrl_unit_p
  import ctrl_unit_p_pkg::*;
#(
  parameter  int NUM_GPR = 4,
  parameter  int MUL_LAT = 3,
  localparam int CW      = 7 + NUM_GPR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [7:0]    instr,
  input  logic          z,
  input  logic          mem_ack,
  output logic          mem_req,
  output logic          mem_sel,
  output logic          mem_we,
  output logic [3:0]    read_sel,
  output logic [CW-1:0] write_en,
  output logic [CW-1:0] inc_en,
  output logic [CW-1:0] clr_en,
  output logic [2:0]    alu_op,
  output logic          end_process,
  output logic          illegal_op
);

  state_e     state, nxt;
  opcode_e    op_q;
  logic [3:0] idx_q;
  logic       mul_last;

  // decode-time view of IR
  opcode_e op_d;
  logic    gpr_ok, bad_idx;
  assign op_d    = opcode_e'(instr[7:4]);
  assign gpr_ok  = int'(instr[3:0]) < NUM_GPR;
  assign bad_idx = (op_d == OP_MVACR || op_d == OP_MVRAC) && !gpr_ok;

  ctrl_mul_timer #(.MUL_LAT(MUL_LAT)) u_mul_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (state == S_DECODE && op_d == OP_MUL),
    .en    (state == S_EXEC && op_q == OP_MUL),
    .last  (mul_last)
  );

  // state register and decode-time opcode latch
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= OP_NOP;
      idx_q <= 4'd0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) begin
        op_q  <= op_d;
        idx_q <= instr[3:0];
      end
    end
  end

  // sticky bad-index flag and registered halt indicator
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      illegal_op  <= 1'b0;
      end_process <= 1'b0;
    end else begin
      if (state == S_DECODE && bad_idx) illegal_op <= 1'b1;
      end_process <= (nxt == S_HALT);
    end
  end

  // next-state and control-vector decode
  always_comb begin
    nxt      = state;
    mem_req  = 1'b0;
    mem_sel  = 1'b0;
    mem_we   = 1'b0;
    read_sel = RS_NONE;
    write_en = '0;
    inc_en   = '0;
    clr_en   = '0;
    alu_op   = ALU_PASS;

    case (state)
      S_IDLE: begin
        if (start) begin
          clr_en[CB_PC] = 1'b1;
          clr_en[CB_AR] = 1'b1;
          clr_en[CB_AC] = 1'b1;
          nxt           = S_FETCH;
        end
      end

      S_FETCH: begin
        mem_req  = 1'b1;
        read_sel = RS_IM;
        if (mem_ack) begin
          write_en[CB_IR] = 1'b1;
          nxt             = S_DECODE;
        end
      end

      S_DECODE: begin
        inc_en[CB_PC] = 1'b1;
        case (op_d)
          OP_NOP:                      nxt = S_FETCH;
          OP_LDAC, OP_LDIAC, OP_STAC:  nxt = S_MEM_ADDR;
          OP_MVACR, OP_MVRAC:          nxt = bad_idx ? S_FETCH : S_EXEC;
          OP_END:                      nxt = S_HALT;
          default:                     nxt = S_EXEC;
        endcase
      end

      S_MEM_ADDR: begin
        write_en[CB_AR] = 1'b1;
        read_sel        = (op_q == OP_LDIAC) ? RS_IR : RS_AC;
        nxt             = S_MEM_WAIT;
      end

      S_MEM_WAIT: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        if (op_q == OP_STAC) begin
          mem_we   = 1'b1;
          read_sel = RS_AC;
          if (mem_ack) write_en[CB_DM] = 1'b1;
        end else begin
          read_sel = RS_DM;
          if (mem_ack) write_en[CB_AC] = 1'b1;
        end
        if (mem_ack) nxt = S_FETCH;
      end

      S_EXEC: begin
        nxt = S_FETCH;
        case (op_q)
          OP_MVACR: begin
            read_sel = RS_AC;
            for (int k = 0; k < NUM_GPR; k++)
              if (idx_q == 4'(k)) write_en[CB_GPR0 + k] = 1'b1;
          end
          OP_MVRAC: begin
            read_sel        = rs_gpr(idx_q);
            write_en[CB_AC] = 1'b1;
          end
          OP_MVACAR: begin
            read_sel        = RS_AC;
            write_en[CB_AR] = 1'b1;
          end
          OP_ADD:    begin alu_op = ALU_ADD;    write_en[CB_ALU] = 1'b1; end
          OP_SUB:    begin alu_op = ALU_SUB;    write_en[CB_ALU] = 1'b1; end
          OP_LSHIFT: begin alu_op = ALU_LSHIFT; write_en[CB_ALU] = 1'b1; end
          OP_MUL: begin
            alu_op = ALU_MUL;
            if (mul_last) write_en[CB_ALU] = 1'b1;
            else          nxt = S_EXEC;
          end
          OP_INAC:  inc_en[CB_AC] = 1'b1;
          OP_CLAC:  clr_en[CB_AC] = 1'b1;
          OP_JPNZ:  nxt = z ? S_FETCH : S_JUMP;
          OP_JMPZ:  nxt = z ? S_JUMP : S_FETCH;
          default:  nxt = S_FETCH;
        endcase
      end

      S_JUMP: begin
        read_sel        = RS_IR;
        write_en[CB_PC] = 1'b1;
        nxt             = S_FETCH;
      end

      S_HALT: begin
        if (start) nxt = S_IDLE;
      end

      default: nxt = S_IDLE;
    endcase

    // reset silences every strobe immediately, not just after the edge
    if (!rst_n) begin
      nxt      = S_IDLE;
      mem_req  = 1'b0;
      mem_sel  = 1'b0;
      mem_we   = 1'b0;
      read_sel = RS_NONE;
      write_en = '0;
      inc_en   = '0;
      clr_en   = '0;
      alu_op   = ALU_PASS;
    end
  end

endmodule

// File: tb/tb_ctrl_unit_p.sv
// Directed bench for ctrl_unit_p (NUM_GPR=2, MUL_LAT=3, CW=9).
module tb_ctrl_unit_p;

  logic       clk = 1'b0;
  logic       rst_n, start, z, mem_ack;
  logic [7:0] instr;
  logic       mem_req, mem_sel, mem_we, end_process, illegal_op;
  logic [3:0] read_sel;
  logic [8:0] write_en, inc_en, clr_en;
  logic [2:0] alu_op;

  int checks   = 0;
  int failures = 0;
  int req_cnt;

  ctrl_unit_p #(.NUM_GPR(2), .MUL_LAT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .instr       (instr),
    .z           (z),
    .mem_ack     (mem_ack),
    .mem_req     (mem_req),
    .mem_sel     (mem_sel),
    .mem_we      (mem_we),
    .read_sel    (read_sel),
    .write_en    (write_en),
    .inc_en      (inc_en),
    .clr_en      (clr_en),
    .alu_op      (alu_op),
    .end_process (end_process),
    .illegal_op  (illegal_op)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        failures++;
        $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
  endtask

  // zero-wait fetch followed by the decode cycle; leaves FSM after DECODE
  task automatic do_fetch(input logic [7:0] ins, input string tag);
    instr   = ins;
    mem_ack = 1'b1;
    #1;
    chk({tag, "_fetch_req"}, {mem_req, mem_sel, read_sel}, {1'b1, 1'b0, 4'd13});
    chk({tag, "_fetch_ir"}, write_en, 9'h004);
    step();
    mem_ack = 1'b0;
    #1;
    chk({tag, "_dec_pcinc"}, inc_en, 9'h001);
    step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; z = 1'b0; mem_ack = 1'b0; instr = 8'h00;
    step(); step();
    chk("rst_strobes", {write_en, inc_en, clr_en, alu_op}, 30'd0);
    rst_n = 1'b1;
    #1;
    chk("idle_outs", {mem_req, end_process, illegal_op, write_en, clr_en}, 21'd0);

    // start clears PC, AR, AC
    start = 1'b1;
    #1;
    chk("start_clr", clr_en, 9'h00B);
    step();
    start = 1'b0;

    // ADD: strobe on cycle 3, fetch again on cycle 4
    do_fetch(8'h70, "add");
    chk("add_exec", {write_en, alu_op}, {9'h040, 3'd1});
    step();
    chk("add_back_fetch", {mem_req, read_sel}, {1'b1, 4'd13});

    // SUB and LSHIFT
    do_fetch(8'h80, "sub");
    chk("sub_exec", {write_en, alu_op}, {9'h040, 3'd2});
    step();
    do_fetch(8'hA0, "lsh");
    chk("lsh_exec", {write_en, alu_op}, {9'h040, 3'd4});
    step();

    // MUL: three cycles of alu_op=3, strobe only in the last
    do_fetch(8'h90, "mul");
    chk("mul_c1", {write_en, alu_op}, {9'h000, 3'd3});
    step();
    chk("mul_c2", {write_en, alu_op}, {9'h000, 3'd3});
    step();
    chk("mul_c3", {write_en, alu_op}, {9'h040, 3'd3});
    step();
    chk("mul_done", {alu_op, mem_req, read_sel}, {3'd0, 1'b1, 4'd13});

    // LDAC with ack delayed by three cycles
    do_fetch(8'h10, "ldac");
    chk("ldac_addr", {write_en, read_sel, mem_req}, {9'h002, 4'd5, 1'b0});
    step();
    req_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (mem_req) req_cnt++;
      chk("ldac_wait", {mem_sel, read_sel, write_en}, {1'b1, 4'd12, 9'h000});
      step();
    end
    mem_ack = 1'b1;
    #1;
    if (mem_req) req_cnt++;
    chk("ldac_ack_load", {write_en, read_sel}, {9'h008, 4'd12});
    chk("ldac_req_cycles", req_cnt, 4);
    step();
    mem_ack = 1'b0;
    #1;
    chk("ldac_next_fetch", {write_en, read_sel}, {9'h000, 4'd13});

    // LDIAC takes address from IR
    do_fetch(8'h20, "ldiac");
    chk("ldiac_addr", {write_en, read_sel}, {9'h002, 4'd4});
    step();
    mem_ack = 1'b1;
    #1;
    chk("ldiac_ack", write_en, 9'h008);
    step();

    // STAC zero-wait
    do_fetch(8'h30, "stac");
    chk("stac_addr", {write_en, read_sel}, {9'h002, 4'd5});
    step();
    mem_ack = 1'b1;
    #1;
    chk("stac_wait", {mem_req, mem_sel, mem_we, read_sel, write_en}, {3'b111, 4'd5, 9'h020});
    step();

    // legal register moves (R2 = index 1 -> bit 8, bus code 8)
    do_fetch(8'h41, "mvacr");
    chk("mvacr_exec", {write_en, read_sel}, {9'h100, 4'd5});
    step();
    do_fetch(8'h51, "mvrac");
    chk("mvrac_exec", {write_en, read_sel}, {9'h008, 4'd8});
    step();
    do_fetch(8'h60, "mvacar");
    chk("mvacar_exec", {write_en, read_sel}, {9'h002, 4'd5});
    step();
    chk("no_illegal_yet", illegal_op, 1'b0);

    // INAC / CLAC
    do_fetch(8'hB0, "inac");
    chk("inac_exec", {inc_en, write_en}, {9'h008, 9'h000});
    step();
    do_fetch(8'hE0, "clac");
    chk("clac_exec", clr_en, 9'h008);
    step();

    // jumps
    z = 1'b0;
    do_fetch(8'hC0, "jpnz_t");
    chk("jpnz_t_exec", write_en, 9'h000);
    step();
    chk("jpnz_t_jump", {write_en, read_sel}, {9'h001, 4'd4});
    step();
    z = 1'b1;
    do_fetch(8'hC0, "jpnz_n");
    step();
    chk("jpnz_n_nojump", {write_en, read_sel}, {9'h000, 4'd13});
    z = 1'b1;
    do_fetch(8'hD0, "jmpz_t");
    step();
    chk("jmpz_t_jump", {write_en, read_sel}, {9'h001, 4'd4});
    step();
    z = 1'b0;
    do_fetch(8'hD0, "jmpz_n");
    step();
    chk("jmpz_n_nojump", {write_en, read_sel}, {9'h000, 4'd13});

    // bad register index: flagged, no GPR strobe, back to fetch
    do_fetch(8'h43, "ill");
    chk("ill_flag", illegal_op, 1'b1);
    chk("ill_nop", {write_en, read_sel}, {9'h000, 4'd13});

    // END -> HALT until start
    do_fetch(8'hF0, "end");
    chk("halt_outs", {end_process, mem_req, write_en, inc_en, clr_en}, {1'b1, 1'b0, 27'd0});
    step();
    chk("halt_hold", end_process, 1'b1);
    start = 1'b1;
    #1;
    chk("halt_start_comb", end_process, 1'b1);
    step();
    start = 1'b0;
    #1;
    chk("idle_after_halt", {end_process, clr_en, mem_req}, {1'b0, 9'h000, 1'b0});
    chk("ill_sticky", illegal_op, 1'b1);

    // reset in MEM_WAIT, then a late ack must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    do_fetch(8'h10, "rst_mw");
    step();
    chk("rst_mw_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mw_quiet", {mem_req, write_en, alu_op}, 13'd0);
    step();
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    #1;
    chk("rst_mw_idle", {mem_req, write_en, illegal_op, end_process}, 12'd0);
    step();
    mem_ack = 1'b0;
    #1;
    chk("rst_mw_stay", {mem_req, write_en}, 10'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
